// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter: FSM states, owner encoding, transfer sizes.
// The tie-break policy is selected by ARB_ROUND_ROBIN_EN (see bus_arbiter.sv).
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // prefer_m1 only matters when both masters request in the same cycle.
    function automatic owner_t pick_owner(input logic req0, input logic req1,
                                          input logic prefer_m1);
        if (req0 && req1)
            return prefer_m1 ? OWN_M1 : OWN_M0;
        if (req1)
            return OWN_M1;
        return OWN_M0;
    endfunction

    function automatic logic [1:0] owner_onehot(input owner_t owner);
        return (owner == OWN_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/response channel used for both masters and the shared downstream bus.
// master modport drives the request fields; slave modport returns data and the completion strobe.
interface bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] address;
    logic          rw;
    logic [DW-1:0] write_data;
    logic [1:0]    size;
    logic          rw_req;
    logic [DW-1:0] read_data;
    logic          rec;

    modport master (
        output address, rw, write_data, size, rw_req,
        input  read_data, rec
    );

    modport slave (
        input  address, rw, write_data, size, rw_req,
        output read_data, rec
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master (CPU m0, DMA m1) arbiter for one shared downstream bus, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build is fixed priority (m0 wins).
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no owner; any pending request is arbitrated at the edge
// BUSY    | owner's fields routed downstream, rw_req high until rec
// RELEASE | one dead cycle so the owner can drop its request
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    bus_arbiter_if.master ds,
    output logic [1:0]    grant,
    output logic          busy
);

    state_t state, state_nxt;
    owner_t owner, owner_nxt;
    logic   tie_pref_m1;
    logic   any_req;

    logic [AW-1:0] sel_address;
    logic          sel_rw;
    logic [DW-1:0] sel_write_data;
    logic [1:0]    sel_size;

    assign any_req = m0.rw_req || m1.rw_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            owner <= OWN_M0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Set when m0 won the last grant, so m1 wins the next tie.
    logic prefer_m1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prefer_m1 <= 1'b0;
        else if (state == ST_IDLE && any_req)
            prefer_m1 <= (owner_nxt == OWN_M0);
    end

    assign tie_pref_m1 = prefer_m1;
`else
    assign tie_pref_m1 = 1'b0;
`endif

    always_comb begin
        sel_address    = m0.address;
        sel_rw         = m0.rw;
        sel_write_data = m0.write_data;
        sel_size       = m0.size;
        if (owner == OWN_M1) begin
            sel_address    = m1.address;
            sel_rw         = m1.rw;
            sel_write_data = m1.write_data;
            sel_size       = m1.size;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        grant         = 2'b00;
        busy          = 1'b0;
        ds.address    = '0;
        ds.rw         = 1'b0;
        ds.write_data = '0;
        ds.size       = 2'b00;
        ds.rw_req     = 1'b0;
        m0.rec        = 1'b0;
        m0.read_data  = '0;
        m1.rec        = 1'b0;
        m1.read_data  = '0;

        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    owner_nxt = pick_owner(m0.rw_req, m1.rw_req, tie_pref_m1);
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                grant         = owner_onehot(owner);
                busy          = 1'b1;
                ds.address    = sel_address;
                ds.rw         = sel_rw;
                ds.write_data = sel_write_data;
                ds.size       = sel_size;
                ds.rw_req     = 1'b1;
                // Completion is forwarded in the same cycle, only to the owner.
                if (ds.rec) begin
                    if (owner == OWN_M1) begin
                        m1.rec       = 1'b1;
                        m1.read_data = ds.read_data;
                    end else begin
                        m0.rec       = 1'b1;
                        m0.read_data = ds.read_data;
                    end
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
